cache_mem_master: RTL
=====================

# cache_mem_master

Block-transfer master that drives the main-memory word interface on behalf of the cache. It accepts one 4-word (16-byte) block request at a time (fill, write-back, or write-back followed by fill), sequences four word beats per block over the `read_or_write`/`address`/`done` handshake, and returns a single 128-bit response to the cache controller. It sits between the cache/TLB miss logic and the main memory model, and is fully synchronous apart from the `mem_done` input, which it synchronizes.

## Interface
- `TIMEOUT_CYCLES`, 64: cycles allowed per beat without a `done` edge before abort.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: cache request valid.
- `req_ready` out 1: high only in IDLE; a request is accepted on `req_valid & req_ready`.
- `req_op` in 2: 00 fill (read), 01 write-back, 10 write-back then fill, 11 illegal (accepted, error response).
- `req_addr` in 10: fill block byte address; bits [3:0] ignored.
- `req_wb_addr` in 10: write-back block byte address; bits [3:0] ignored.
- `req_wdata` in 128: write-back block; word i is at [32i+31:32i].
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: valid with `resp_valid`; 1 on timeout or illegal op.
- `resp_rdata` out 128: filled block, same packing; held until the next fill completes.
- `mem_read_or_write` out 1: 1 = write, 0 = read.
- `mem_address` out 10: word byte address `{blk[9:4], beat[1:0], 2'b00}`.
- `mem_write_data` out 32: write word for the current beat.
- `mem_done` in 1: per-word completion pulse from memory, asynchronous to `clk`.
- `mem_read_data` in 32: read word, valid when `mem_done` rises.

## Operation
- Reset: state IDLE, beat=0, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read_or_write`=0, `mem_address`=0, `mem_write_data`=0, sync flops and timeout counter=0.
- `mem_done` passes a 2-flop synchronizer; a beat completes on a rising edge of the synchronized signal (`done_edge`).
- States: IDLE, WB, RD, RESP.
- IDLE: on accept, latch op, both addresses and `req_wdata`; op 00 -> RD, op 01/10 -> WB, op 11 -> RESP with err=1.
- WB: drive `mem_read_or_write`=1, `mem_address` = wb block + beat, `mem_write_data` = word[beat]. On `done_edge`, beat++. After beat 3: op 01 -> RESP, op 10 -> RD with beat=0.
- RD: drive `mem_read_or_write`=0, `mem_address` = fill block + beat. On `done_edge`, capture `mem_read_data` into word[beat] and beat++. After beat 3 -> RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
- Memory outputs change only at a beat boundary. They hold their last value in IDLE and RESP, because any change on `address` or `read_or_write` starts a memory access. Beat 3 and beat 0 addresses always differ, so a back-to-back request to the same block still produces a change.
- Timeout: the counter clears at each beat start and increments each cycle in WB/RD. At `TIMEOUT_CYCLES` without `done_edge`, go to RESP with err=1. Partially filled `resp_rdata` words are not committed; fills update `resp_rdata` only on error-free completion.
- A `done_edge` while in IDLE or RESP is ignored, including stale pulses after an abort or reset.

## Timing
- Accept at edge N; beat-0 outputs are valid after edge N+1.
- Each beat takes the memory response time plus 2–3 cycles of synchronizer and edge latency. Next-beat outputs update on the edge after `done_edge`.
- `resp_valid` is asserted the cycle after the last beat's `done_edge`. `req_ready` stays low from the accept edge until RESP exits.
- Reset asserted mid-transfer aborts immediately to reset values; no response is issued.

## Test plan
- Fill: bench memory words 0x40–0x4C = CCCCCCCC, EEEEEEEE, 55555555, BBBBBBBB; op 00, `req_addr`=0x045 -> addresses 0x040, 0x044, 0x048, 0x04C in order; `resp_rdata`=BBBBBBBB_55555555_EEEEEEEE_CCCCCCCC, err=0.
- Write-back: op 01, `req_wb_addr`=0x100, wdata=44444444_33333333_22222222_11111111 -> 4 writes with `mem_read_or_write`=1; memory words 0x100–0x10C hold 11111111…44444444; `resp_rdata` unchanged.
- Write-back then fill: op 10, wb 0x100, fill 0x040 -> 4 writes then 4 reads with no gap request; exactly one `resp_valid`.
- Back-to-back fills of 0x040 -> second request still produces 4 `done` pulses and identical data.
- Timeout: the memory never pulses `done` -> `resp_valid`=1, `resp_err`=1 after `TIMEOUT_CYCLES`; a late `done` in IDLE is ignored. Op 11 -> immediate error response.
- Reset asserted mid-beat 2 of a fill -> all outputs return to reset values, no `resp_valid`; the next fill completes normally.

Source files
------------

// File: rtl/cache_mem_master.sv
// Block-transfer master: moves one 4-word cache block per request over the
// main-memory word handshake and returns a single 128-bit response.
module cache_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [1:0]   i_req_op,
  input  logic [9:0]   i_req_addr,
  input  logic [9:0]   i_req_wb_addr,
  input  logic [127:0] i_req_wdata,
  output logic         o_resp_valid,
  output logic         o_resp_err,
  output logic [127:0] o_resp_rdata,
  output logic         o_mem_read_or_write,
  output logic [9:0]   o_mem_address,
  output logic [31:0]  o_mem_write_data,
  input  logic         i_mem_done,
  input  logic [31:0]  i_mem_read_data
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BLKA_W = 6;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_WB   = 2'b01;
  localparam logic [1:0] OP_WBF  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [TCNT_W-1:0]   w_tcnt_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [1:0]          r_op;
  logic [BLKA_W-1:0]   r_fill_blk;
  logic [BLKA_W-1:0]   r_wb_blk;
  logic [BLK_W-1:0]    r_wdata;
  logic [BLK_W-1:0]    r_rbuf;
  logic [BLK_W-1:0]    w_rd_block;
  logic                w_accept;
  logic                w_capture;
  logic                w_commit;

  logic [1:0]          r_sync;
  logic                r_done_prev;
  logic                w_done_edge;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [BLK_W-1:0]    r_resp_rdata;
  logic                r_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;

  logic                w_unused;
  assign w_unused = ^{i_req_addr[3:0], i_req_wb_addr[3:0]};

  assign w_done_edge = r_sync[1] & ~r_done_prev;

  // mem_done crosses in through two flops; a third flop gives the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b00;
      r_done_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_mem_done};
      r_done_prev <= r_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_rd_block  = r_rbuf;
    w_rd_block[{r_beat, 5'd0} +: WORD_W] = i_mem_read_data;

    unique case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept   = 1'b1;
          w_beat_nxt = '0;
          w_tcnt_nxt = '0;
          w_err_nxt  = 1'b0;
          unique case (i_req_op)
            OP_FILL:       w_state_nxt = S_RD;
            OP_WB, OP_WBF: w_state_nxt = S_WB;
            default: begin
              w_state_nxt = S_RESP;
              w_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_WB, S_RD: begin
        if (w_done_edge) begin
          w_tcnt_nxt = '0;
          w_beat_nxt = r_beat + BEAT_W'(1);
          w_capture  = (r_state == S_RD);
          if (r_beat == BEAT_W'(3)) begin
            if (r_state == S_RD) begin
              w_commit    = 1'b1;
              w_state_nxt = S_RESP;
            end else begin
              w_state_nxt = (r_op == OP_WBF) ? S_RD : S_RESP;
            end
          end
        end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat       <= '0;
      r_tcnt       <= '0;
      r_err        <= 1'b0;
      r_op         <= OP_FILL;
      r_fill_blk   <= '0;
      r_wb_blk     <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_beat       <= w_beat_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_err        <= w_err_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_resp_err   <= (w_state_nxt == S_RESP) & w_err_nxt;
      if (w_accept) begin
        r_op       <= i_req_op;
        r_fill_blk <= i_req_addr[ADDR_W-1:4];
        r_wb_blk   <= i_req_wb_addr[ADDR_W-1:4];
        r_wdata    <= i_req_wdata;
      end
      if (w_capture) begin
        r_rbuf <= w_rd_block;
      end
      if (w_commit) begin
        r_resp_rdata <= w_rd_block;
      end
      // Memory pins only move inside a transfer; IDLE/RESP hold the last beat
      unique case (r_state)
        S_WB: begin
          r_mem_rw    <= 1'b1;
          r_mem_addr  <= {r_wb_blk, r_beat, 2'b00};
          r_mem_wdata <= r_wdata[{r_beat, 5'd0} +: WORD_W];
        end
        S_RD: begin
          r_mem_rw   <= 1'b0;
          r_mem_addr <= {r_fill_blk, r_beat, 2'b00};
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready         = r_req_ready;
  assign o_resp_valid        = r_resp_valid;
  assign o_resp_err          = r_resp_err;
  assign o_resp_rdata        = r_resp_rdata;
  assign o_mem_read_or_write = r_mem_rw;
  assign o_mem_address       = r_mem_addr;
  assign o_mem_write_data    = r_mem_wdata;

endmodule
